mem_bank_ctrl: RTL and testbench
================================

// Module: mem_bank_ctrl
// PURPOSE
//  Parametrised single-port data memory with per-byte-lane store/load masking and a hardware wipe sequencer.
//  Replaces the single-cycle whole-array clear with a counter-driven sweep that clears one word per cycle.
//  Sits on the CPU data path behind the load/store unit; the busy output stalls the pipeline during a wipe.
// PARAMETERS
//  ADDR_BITS  10  word-address width; DEPTH = 1<<ADDR_BITS words
//  DATA_BITS  32  word width; must be a multiple of 8; LANES = DATA_BITS/8 (localparam)
// PORTS
//  clk       in   1          rising-edge clock
//  clr       in   1          asynchronous reset, active-high
//  wipe      in   1          request a full-array zero sweep (sampled in IDLE only)
//  addr      in   ADDR_BITS  word address
//  data_in   in   DATA_BITS  store data
//  sel       in   LANES      byte-lane enable; bit k covers bits [8k+7:8k]
//  str       in   1          store selected lanes of data_in to memory[addr]
//  ld        in   1          load memory[addr] masked by sel into data_out
//  busy      out  1          1 while the wipe sequencer owns the array
//  data_out  out  DATA_BITS  registered load result
//  par_err   out  1          registered parity error flag for the current load (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (clr=1, async): state<=WIPE, ptr<=0, busy<=1, data_out<=0, par_err<=0; array contents are undefined until the sweep ends.
//  - FSM states: WIPE, IDLE.
//    WIPE: each clk writes 0 to memory[ptr] and ptr<=ptr+1; when ptr==DEPTH-1 the write occurs, then state<=IDLE, busy<=0.
//      The sweep takes exactly DEPTH cycles after reset release. wipe, str and ld are ignored. data_out<=0, par_err<=0.
//    IDLE: wipe=1 -> state<=WIPE, ptr<=0, busy<=1 next cycle; str/ld in that same cycle are ignored (wipe has priority).
//  - Store (IDLE, str=1): for each lane k, memory[addr] lane k <= data_in lane k if sel[k], else unchanged. sel=0 leaves the word unchanged.
//  - Load (IDLE): data_out <= ld ? (word & lane-mask(sel)) : 0; latency 1 clk; unselected lanes read 0.
//  - str and ld together at the same addr: write-first; data_out shows the newly merged word.
//  - addr wraps naturally at DEPTH; there is no out-of-range access.
//  - clr asserted mid-sweep or mid-access: the sweep restarts from ptr=0 on release; any in-flight store may or may not land (its word is re-cleared by the sweep).
//  - busy is a registered output: high in the first cycle after reset and low in the cycle after the final sweep write.
// CONFIGURATION
//  Macro MEM_PARITY_EN:
//   defined: each lane stores an extra even-parity bit, written on store and cleared to 0 by the sweep.
//     On load, par_err<=1 if any selected lane's stored parity != ^(stored byte); data_out is returned unchanged.
//     par_err<=0 when ld=0 or busy=1.
//   undefined: no parity storage; par_err is tied to 0.
// TESTING
//  1. Reset release, DEPTH=1024 -> busy=1 for exactly 1024 clks, then 0; ld addr 0x3FF sel=4'hF -> data_out=0.
//  2. str addr 5, data_in=32'hA1B2C3D4, sel=4'hF; then ld addr 5 sel=4'b0101 -> data_out=32'h00B200D4 one clk later.
//  3. Partial store addr 5, data_in=32'h11223344, sel=4'b1000; ld sel=4'hF -> 32'h11B2C3D4.
//  4. Same-cycle str+ld addr 9, data_in=32'hDEADBEEF, sel=4'hF -> data_out=32'hDEADBEEF the next clk (write-first).
//  5. wipe pulse in IDLE together with str addr 2 -> store dropped, busy rises next clk, after DEPTH clks addr 5 reads 0; clr during sweep restarts the count.
//  6. MEM_PARITY_EN: store 32'h000000FF, force lane-0 parity bit flipped, ld sel=4'h1 -> par_err=1; ld sel=4'h2 -> par_err=0.

Source files
------------

// File: rtl/mem_bank_ctrl.sv
// Single-port data memory with per-lane store/load masking and a one-word-per-cycle wipe sweep.
// Optional per-lane even parity storage and check when MEM_PARITY_EN is defined.
module mem_bank_ctrl #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wipe,
  input  logic [ADDR_BITS-1:0]     addr,
  input  logic [DATA_BITS-1:0]     data_in,
  input  logic [DATA_BITS/8-1:0]   sel,
  input  logic                     str,
  input  logic                     ld,
  output logic                     busy,
  output logic [DATA_BITS-1:0]     data_out,
  output logic                     par_err
);

  localparam int LANES = DATA_BITS / 8;
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {IDLE = 1'b0, WIPE = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] ptr, ptr_nxt;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rd_word, merged, lane_mask, dout_nxt;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdat;

  // Write-first merge: a same-cycle load observes the lanes being stored.
  assign rd_word = mem[addr];
  always_comb begin
    lane_mask = '0;
    merged    = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_mask[8*k +: 8] = {8{sel[k]}};
      merged[8*k +: 8]    = (str && sel[k]) ? data_in[8*k +: 8] : rd_word[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= WIPE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      WIPE: begin
        ptr_nxt = ptr + ADDR_BITS'(1);
        if (ptr == {ADDR_BITS{1'b1}}) state_nxt = IDLE;
      end
      default: begin
        if (wipe) begin
          state_nxt = WIPE;
          ptr_nxt   = '0;
        end
      end
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdat  = merged;
    dout_nxt  = '0;
    case (state)
      WIPE: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdat  = '0;
      end
      default: begin
        if (!wipe) begin
          mem_we = str;
          if (ld) dout_nxt = merged & lane_mask;
        end
      end
    endcase
  end

  // state is a single flop whose WIPE encoding is 1, so busy is a registered output.
  assign busy = state;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) data_out <= '0;
    else     data_out <= dout_nxt;
  end

`ifdef MEM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] rd_par, merged_par, calc_par, par_wdat;
  logic             perr_nxt;

  assign rd_par = par_mem[addr];
  always_comb begin
    merged_par = '0;
    calc_par   = '0;
    for (int k = 0; k < LANES; k++) begin
      merged_par[k] = (str && sel[k]) ? ^data_in[8*k +: 8] : rd_par[k];
      calc_par[k]   = ^merged[8*k +: 8];
    end
  end

  assign par_wdat = (state == WIPE) ? '0 : merged_par;
  assign perr_nxt = (state == IDLE) && !wipe && ld && |(sel & (merged_par ^ calc_par));

  always_ff @(posedge clk) begin
    if (mem_we) par_mem[mem_waddr] <= par_wdat;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) par_err <= 1'b0;
    else     par_err <= perr_nxt;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed bench for mem_bank_ctrl: sweep length, masked store/load, write-first, wipe and clr restart.
module tb_mem_bank_ctrl;

  localparam int ADDR_BITS = 10;
  localparam int DATA_BITS = 32;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic                 clk = 1'b0;
  logic                 clr;
  logic                 wipe;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] data_in;
  logic [3:0]           sel;
  logic                 str;
  logic                 ld;
  logic                 busy;
  logic [DATA_BITS-1:0] data_out;
  logic                 par_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bank_ctrl #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) dut (
    .clk(clk), .clr(clr), .wipe(wipe), .addr(addr), .data_in(data_in),
    .sel(sel), .str(str), .ld(ld), .busy(busy), .data_out(data_out), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wipe = 0; str = 0; ld = 0; sel = 4'h0; addr = '0; data_in = '0;
  endtask

  // Counts negedge samples with busy high; optionally pokes a store+load mid-sweep.
  task automatic count_busy(input bit inject, output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      if (inject && n == 50) begin
        str = 1; ld = 1; addr = 10'd7; data_in = 32'hFFFF_FFFF; sel = 4'hF;
      end
      if (inject && n == 51) begin
        chk("ld_during_sweep", data_out, 32'h0);
        idle_inputs();
      end
      n++;
      cyc();
    end
  endtask

  task automatic do_store(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    idle_inputs(); str = 1; addr = a; data_in = d; sel = s;
    cyc();
    idle_inputs();
  endtask

  task automatic do_load(input logic [9:0] a, input logic [3:0] s);
    idle_inputs(); ld = 1; addr = a; sel = s;
    cyc();
    idle_inputs();
  endtask

  initial begin
    int n;
    idle_inputs();
    clr = 1;
    @(negedge clk);
    cyc();
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_par_err", 32'(par_err), 32'h0);
    clr = 0;

    count_busy(1'b0, n);
    chk("sweep_len", 32'(n), 32'(DEPTH));
    chk("busy_low", 32'(busy), 32'h0);

    do_load(10'h3FF, 4'hF);
    chk("ld_top_after_sweep", data_out, 32'h0);

    do_store(10'd5, 32'hA1B2_C3D4, 4'hF);
    do_load(10'd5, 4'b0101);
    chk("ld_masked_0101", data_out, 32'h00B2_00D4);
    chk("par_err_clean", 32'(par_err), 32'h0);

    do_store(10'd5, 32'h1122_3344, 4'b1000);
    do_load(10'd5, 4'hF);
    chk("partial_store", data_out, 32'h11B2_C3D4);

    do_store(10'd5, 32'hFFFF_FFFF, 4'h0);
    do_load(10'd5, 4'hF);
    chk("sel0_store_noop", data_out, 32'h11B2_C3D4);

    do_load(10'd5, 4'h0);
    chk("ld_sel0", data_out, 32'h0);

    idle_inputs(); addr = 10'd5; sel = 4'hF;
    cyc();
    chk("no_ld_zero", data_out, 32'h0);

    idle_inputs(); str = 1; ld = 1; addr = 10'd9; data_in = 32'hDEAD_BEEF; sel = 4'hF;
    cyc();
    chk("write_first", data_out, 32'hDEAD_BEEF);
    idle_inputs();
    do_load(10'd9, 4'b0011);
    chk("ld_9_low", data_out, 32'h0000_BEEF);

`ifdef MEM_PARITY_EN
    do_store(10'd6, 32'h0000_00FF, 4'hF);
    dut.par_mem[6][0] = ~dut.par_mem[6][0];
    do_load(10'd6, 4'h1);
    chk("par_err_lane0", 32'(par_err), 32'h1);
    chk("par_data_unchanged", data_out, 32'h0000_00FF);
    do_load(10'd6, 4'h2);
    chk("par_err_lane1", 32'(par_err), 32'h0);
`endif

    // Wipe wins over a same-cycle store and load.
    idle_inputs(); wipe = 1; str = 1; ld = 1; addr = 10'd2; data_in = 32'hFFFF_FFFF; sel = 4'hF;
    cyc();
    idle_inputs();
    chk("wipe_busy", 32'(busy), 32'h1);
    chk("wipe_ld_ignored", data_out, 32'h0);

    repeat (100) cyc();
    clr = 1;
    cyc();
    clr = 0;
    count_busy(1'b1, n);
    chk("sweep_restart_len", 32'(n), 32'(DEPTH));

    do_load(10'd5, 4'hF);
    chk("addr5_wiped", data_out, 32'h0);
    do_load(10'd2, 4'hF);
    chk("addr2_store_dropped", data_out, 32'h0);
    do_load(10'd7, 4'hF);
    chk("addr7_sweep_store_ignored", data_out, 32'h0);
    do_load(10'd9, 4'hF);
    chk("addr9_wiped", data_out, 32'h0);
    chk("par_err_end", 32'(par_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
